avalon_st_pkt_sink: RTL and testbench

//  Avalon-ST sink at the far end of the concentrator stream: drives sink_ready, accepts

---
 rtl/avalon_st_pkt_sink.sv | 114 +++++++++++
 tb/tb_avalon_st_pkt_sink.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_sink.sv
// avalon_st_pkt_sink: Avalon-ST packet sink checking framing, length and trailing CRC-8
module avalon_st_pkt_sink #(
    parameter int unsigned MAX_LEN   = 64,
    parameter logic [7:0]  CRC_POLY  = 8'h07,
    parameter logic [7:0]  READY_PAT = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  avalon_st_data,
    input  logic        avalon_st_valid,
    input  logic        avalon_st_startofpacket,
    input  logic        avalon_st_endofpacket,
    output logic        sink_ready,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [7:0]  pkt_chan,
    output logic [7:0]  pkt_len,
    output logic [3:0]  err_flags,
    output logic [15:0] stray_cnt,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] phase;
    logic [7:0] chan, len, crc, len_inc;
    logic [3:0] flags;
    logic pend, pend_eop, acc, sop, eop, ov;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? {r[6:0], 1'b0} ^ CRC_POLY : {r[6:0], 1'b0};
        return r;
    endfunction

    always_comb begin
        sink_ready = READY_PAT[phase] && state != DONE;
        acc = avalon_st_valid & sink_ready;
        sop = acc & avalon_st_startofpacket;
        eop = acc & avalon_st_endofpacket;
        len_inc = len + {7'd0, len != 8'hFF};
        ov = 32'(len) >= MAX_LEN;
        pkt_done = state == DONE;
        pkt_ok = pkt_done && err_flags == 4'd0;
        state_nx = state == IDLE ? (sop ? (eop ? DONE : RECV) : IDLE) :
                   state == RECV ? (sop || eop ? DONE : RECV) :
                   pend ? (pend_eop ? DONE : RECV) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            chan <= '0;
            len <= '0;
            crc <= '0;
            flags <= '0;
            pend <= 1'b0;
            pend_eop <= 1'b0;
            pkt_chan <= '0;
            pkt_len <= '0;
            err_flags <= '0;
            stray_cnt <= '0;
            good_cnt <= '0;
            err_cnt <= '0;
        end else begin
            phase <= phase + 3'd1;
            if (state == DONE) begin
                if (pkt_ok) good_cnt <= good_cnt + {15'd0, ~&good_cnt};
                else err_cnt <= err_cnt + {15'd0, ~&err_cnt};
                pend <= 1'b0;
                pend_eop <= 1'b0;
                if (pend_eop) begin
                    pkt_chan <= chan;
                    pkt_len <= len;
                    err_flags <= flags;
                end
            end else if (sop) begin
                if (state == RECV) begin
                    pkt_chan <= chan;
                    pkt_len <= len;
                    err_flags <= flags | 4'b0001;
                    pend <= 1'b1;
                    pend_eop <= eop;
                end else if (eop) begin
                    pkt_chan <= avalon_st_data;
                    pkt_len <= 8'd1;
                    err_flags <= 4'b0010;
                end
                chan <= avalon_st_data;
                len <= 8'd1;
                crc <= crc8(8'd0, avalon_st_data);
                flags <= eop ? 4'b0010 : 4'b0000;
            end else if (acc && state == IDLE) begin
                stray_cnt <= stray_cnt + {15'd0, ~&stray_cnt};
            end else if (acc) begin
                len <= len_inc;
                crc <= crc8(crc, avalon_st_data);
                flags <= flags | {1'b0, ov, 2'b00};
                if (eop) begin
                    pkt_chan <= chan;
                    pkt_len <= len_inc;
                    err_flags <= flags | {avalon_st_data != crc, ov, 2'b00};
                end
            end
        end
    end
endmodule

// File: tb/tb_avalon_st_pkt_sink.sv
// tb_avalon_st_pkt_sink: three sink instances checked every cycle against a packet-level model
module tb_avalon_st_pkt_sink;
    localparam int N = 3;
    localparam logic [7:0] PAT [N] = '{8'hFF, 8'h55, 8'hFF};
    localparam int unsigned ML [N] = '{64, 64, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] d_in [N];
    logic v_in [N], s_in [N], e_in [N];
    logic rdy [N], done [N], ok [N];
    logic [7:0] chan [N], len [N];
    logic [3:0] flg [N];
    logic [15:0] stray [N], good [N], errc [N];
    int n_chk = 0, n_fail = 0, tcyc = 0, last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        avalon_st_pkt_sink #(.MAX_LEN(ML[g]), .CRC_POLY(8'h07), .READY_PAT(PAT[g])) u_dut (
            .clk(clk), .rst(rst), .avalon_st_data(d_in[g]), .avalon_st_valid(v_in[g]),
            .avalon_st_startofpacket(s_in[g]), .avalon_st_endofpacket(e_in[g]),
            .sink_ready(rdy[g]), .pkt_done(done[g]), .pkt_ok(ok[g]), .pkt_chan(chan[g]),
            .pkt_len(len[g]), .err_flags(flg[g]), .stray_cnt(stray[g]), .good_cnt(good[g]),
            .err_cnt(errc[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: packets kept as beat lists, judged whole when they close
    int m_cyc [N], m_n [N];
    logic [7:0] m_buf [N][256];
    logic m_in [N], m_done [N], m_pend [N], m_ok [N];
    logic [7:0] m_chan [N], m_len [N];
    logic [3:0] m_flg [N];
    logic [15:0] m_stray [N], m_good [N], m_err [N];

    function automatic logic [7:0] crc_of(input int k, input int cnt);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int j = 0; j < cnt; j++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ m_buf[k][j][b];
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        return c;
    endfunction

    task automatic close(input int k, input logic abort);
        int n;
        logic [3:0] f;
        n = m_n[k];
        f[0] = abort;
        f[1] = !abort && n == 1;
        f[2] = n > int'(ML[k]);
        f[3] = !abort && n > 1 && crc_of(k, n - 1) != m_buf[k][n - 1];
        m_chan[k] = m_buf[k][0];
        m_len[k] = n > 255 ? 8'd255 : 8'(n);
        m_flg[k] = f;
        m_ok[k] = f == 4'd0;
    endtask

    task automatic model_step(input int k);
        logic [7:0] p;
        logic a, nd;
        if (rst) begin
            m_cyc[k] = 0; m_n[k] = 0; m_in[k] = 0; m_done[k] = 0; m_pend[k] = 0; m_ok[k] = 0;
            m_chan[k] = 0; m_len[k] = 0; m_flg[k] = 0; m_stray[k] = 0; m_good[k] = 0; m_err[k] = 0;
        end else begin
            p = PAT[k];
            a = v_in[k] && p[m_cyc[k] % 8] && !m_done[k];
            nd = 1'b0;
            if (m_done[k]) begin
                if (m_ok[k]) begin
                    if (m_good[k] != 16'hFFFF) m_good[k]++;
                end else if (m_err[k] != 16'hFFFF) m_err[k]++;
            end
            if (m_done[k] && m_pend[k]) begin
                close(k, 1'b0);
                nd = 1'b1;
                m_pend[k] = 1'b0;
                m_in[k] = 1'b0;
            end else if (a && s_in[k]) begin
                if (m_in[k]) begin
                    close(k, 1'b1);
                    nd = 1'b1;
                end
                m_n[k] = 1;
                m_buf[k][0] = d_in[k];
                m_in[k] = 1'b1;
                if (e_in[k]) begin
                    if (nd) m_pend[k] = 1'b1;
                    else begin
                        close(k, 1'b0);
                        nd = 1'b1;
                        m_in[k] = 1'b0;
                    end
                end
            end else if (a && m_in[k]) begin
                if (m_n[k] < 256) m_buf[k][m_n[k]] = d_in[k];
                m_n[k]++;
                if (e_in[k]) begin
                    close(k, 1'b0);
                    nd = 1'b1;
                    m_in[k] = 1'b0;
                end
            end else if (a && m_stray[k] != 16'hFFFF) m_stray[k]++;
            m_done[k] = nd;
            m_cyc[k]++;
        end
    endtask

    always @(posedge clk)
        for (int k = 0; k < N; k++) model_step(k);

    typedef struct {int k; logic ok; logic [7:0] chan, len; logic [3:0] flg; int cyc;} res_t;
    res_t rq[$];

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin : cmp
            logic [7:0] p;
            p = PAT[k];
            chk($sformatf("i%0d ready", k), rdy[k], p[m_cyc[k] % 8] && !m_done[k]);
            chk($sformatf("i%0d pkt_done", k), done[k], m_done[k]);
            chk($sformatf("i%0d stray_cnt", k), stray[k], m_stray[k]);
            chk($sformatf("i%0d good_cnt", k), good[k], m_good[k]);
            chk($sformatf("i%0d err_cnt", k), errc[k], m_err[k]);
            if (m_done[k]) begin
                chk($sformatf("i%0d pkt_ok", k), ok[k], m_ok[k]);
                chk($sformatf("i%0d pkt_chan", k), chan[k], m_chan[k]);
                chk($sformatf("i%0d pkt_len", k), len[k], m_len[k]);
                chk($sformatf("i%0d err_flags", k), flg[k], m_flg[k]);
            end
            if (done[k]) rq.push_back('{k, ok[k], chan[k], len[k], flg[k], tcyc});
        end
    end

    task automatic expect_res(input string nm, input int k, input logic eok, input logic [7:0] ech,
                              input logic [7:0] elen, input logic [3:0] eflg, input logic [3:0] emask,
                              input int eacc);
        res_t r;
        if (rq.size() == 0) chk({nm, " result present"}, 0, 1);
        else begin
            r = rq.pop_front();
            chk({nm, " instance"}, r.k, k);
            chk({nm, " ok"}, r.ok, eok);
            chk({nm, " chan"}, r.chan, ech);
            chk({nm, " len"}, r.len, elen);
            chk({nm, " flags"}, r.flg & emask, eflg);
            if (eacc >= 0) chk({nm, " latency"}, r.cyc - eacc, 1);
        end
    endtask

    task automatic beat(input int k, input logic [7:0] d, input logic s, input logic e);
        int t;
        t = 0;
        @(negedge clk);
        d_in[k] = d; v_in[k] = 1'b1; s_in[k] = s; e_in[k] = e;
        while (!rdy[k] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("handshake within bound", t < 40, 1);
        last_acc = tcyc;
        @(posedge clk);
    endtask

    logic [7:0] pk[$];

    task automatic send(input int k, input logic with_eop);
        for (int i = 0; i < pk.size(); i++)
            beat(k, pk[i], i == 0, with_eop && i == pk.size() - 1);
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        v_in[k] = 1'b0; s_in[k] = 1'b0; e_in[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            v_in[k] = 1'b0; s_in[k] = 1'b0; e_in[k] = 1'b0; d_in[k] = 8'h00;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        for (int k = 0; k < N; k++) begin
            v_in[k] = 1'b0; s_in[k] = 1'b0; e_in[k] = 1'b0; d_in[k] = 8'h00;
        end
        do_reset();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst i%0d ready", k), rdy[k], 1);
            chk($sformatf("rst i%0d done", k), done[k], 0);
            chk($sformatf("rst i%0d ok", k), ok[k], 0);
            chk($sformatf("rst i%0d chan", k), chan[k], 0);
            chk($sformatf("rst i%0d len", k), len[k], 0);
            chk($sformatf("rst i%0d flags", k), flg[k], 0);
            chk($sformatf("rst i%0d counters", k), {stray[k], good[k] | errc[k]}, 0);
        end

        pk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        send(0, 1); a = last_acc; idle(0); repeat (3) @(negedge clk);
        expect_res("t1", 0, 1, 8'h31, 8'd10, 4'h0, 4'hF, a);
        chk("t1 good_cnt", good[0], 1);
        chk("t1 err_cnt", errc[0], 0);

        do_reset();
        pk[9] = 8'hF5;
        send(0, 1); a = last_acc; idle(0); repeat (3) @(negedge clk);
        expect_res("t2", 0, 0, 8'h31, 8'd10, 4'b1000, 4'hF, a);
        chk("t2 err_cnt", errc[0], 1);
        chk("t2 good_cnt", good[0], 0);

        do_reset();
        pk[9] = 8'hF4;
        send(1, 1); a = last_acc; idle(1); repeat (3) @(negedge clk);
        expect_res("t3", 1, 1, 8'h31, 8'd10, 4'h0, 4'hF, a);
        chk("t3 good_cnt", good[1], 1);

        do_reset();
        pk = '{8'hAA};
        send(0, 1); a = last_acc; idle(0); repeat (2) @(negedge clk);
        expect_res("t4 runt", 0, 0, 8'hAA, 8'd1, 4'b0010, 4'hF, a);
        for (int i = 0; i < 3; i++) beat(0, 8'h50 + 8'(i), 1'b0, 1'b0);
        idle(0); repeat (3) @(negedge clk);
        chk("t4 stray_cnt", stray[0], 3);
        chk("t4 no extra pkt_done", rq.size(), 0);

        do_reset();
        pk = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send(2, 1); a = last_acc; idle(2); repeat (3) @(negedge clk);
        expect_res("t5 overlen", 2, 0, 8'h10, 8'd6, 4'b0100, 4'b0100, a);
        chk("t5 single pkt_done", rq.size(), 0);
        pk = '{8'h10, 8'h11, 8'h12, 8'h9E};
        send(2, 1); a = last_acc; idle(2); repeat (3) @(negedge clk);
        expect_res("t5 at max_len", 2, 1, 8'h10, 8'd4, 4'h0, 4'hF, a);

        do_reset();
        pk = '{8'h31, 8'h32};
        send(0, 0);
        pk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        send(0, 1); a = last_acc; idle(0); repeat (4) @(negedge clk);
        expect_res("t6 abort", 0, 0, 8'h31, 8'd2, 4'b0001, 4'hF, -1);
        expect_res("t6 next", 0, 1, 8'h31, 8'd10, 4'h0, 4'hF, a);
        chk("t6 err_cnt", errc[0], 1);
        chk("t6 good_cnt", good[0], 1);

        pk = '{8'h31, 8'h32};
        send(0, 0);
        beat(0, 8'hAB, 1'b1, 1'b1); idle(0); repeat (4) @(negedge clk);
        expect_res("abort then runt a", 0, 0, 8'h31, 8'd2, 4'b0001, 4'hF, -1);
        expect_res("abort then runt b", 0, 0, 8'hAB, 8'd1, 4'b0010, 4'hF, -1);

        pk = '{8'h31, 8'h32, 8'h33};
        send(0, 0);
        do_reset();
        chk("mid rst counters", {stray[0], good[0], errc[0]}, 0);
        repeat (4) @(negedge clk);
        chk("mid rst no pkt_done", rq.size(), 0);
        pk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        send(0, 1); a = last_acc; idle(0); repeat (3) @(negedge clk);
        expect_res("after mid rst", 0, 1, 8'h31, 8'd10, 4'h0, 4'hF, a);

        chk("no leftover results", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
